array_store: RTL and testbench

//  Write-back side of the 7x13 window loader. Collects the 7 corrected 4-pixel words (window cols 7..13)

---
 rtl/array_store_pkg.sv | 13 +
 rtl/array_store_if.sv | 13 +
 rtl/replace_row_reg.sv | 27 ++
 rtl/array_store.sv | 110 +++++++++++
 tb/tb_array_store.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/array_store_pkg.sv
// rtl/array_store_pkg.sv - shared defaults and FSM state type for the window write-back store
package array_store_pkg;
    localparam int DW_IN_DEFAULT         = 10;
    localparam int WORDS_DEFAULT         = 7;
    localparam int ROW_CNT_WIDTH_DEFAULT = 4;
    localparam int DW_WORD               = DW_IN_DEFAULT * 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;
endpackage

// File: rtl/array_store_if.sv
// rtl/array_store_if.sv - corrected-word handshake between correction core and array_store
interface array_store_if
    import array_store_pkg::*;
#(
    parameter int WIDTH = DW_WORD
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;

    modport master (output in_valid, output data_in, input in_ready);
    modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/replace_row_reg.sv
// rtl/replace_row_reg.sv - WORDS x DW_WORD register row with row load, per-word write and sync clear
module replace_row_reg #(
    parameter int WORDS   = 7,
    parameter int DW_WORD = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     load,
    input  logic [WORDS-1:0]         word_we,
    input  logic [WORDS*DW_WORD-1:0] d,
    output logic [WORDS*DW_WORD-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            for (int k = 0; k < WORDS; k++) begin
                if (word_we[k]) begin
                    q[k*DW_WORD +: DW_WORD] <= d[k*DW_WORD +: DW_WORD];
                end
            end
        end
    end
endmodule

// File: rtl/array_store.sv
// rtl/array_store.sv - captures one corrected 7-word row and commits it into a 3-deep replace-line bank
module array_store
    import array_store_pkg::*;
#(
    parameter int DW_IN         = DW_IN_DEFAULT,
    parameter int WORDS         = WORDS_DEFAULT,
    parameter int ROW_CNT_WIDTH = ROW_CNT_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       store_start,
    array_store_if.slave               word_bus,
    output logic [DW_IN*4*WORDS-1:0]   imo_replace_line1,
    output logic [DW_IN*4*WORDS-1:0]   imo_replace_line2,
    output logic [DW_IN*4*WORDS-1:0]   imo_replace_line3,
    output logic [ROW_CNT_WIDTH-1:0]   row_cnt,
    output logic                       store_done
);
    localparam int WORD_W = DW_IN * 4;
    localparam int ROW_W  = WORD_W * WORDS;

    state_t            state;
    logic [2:0]        idx;
    logic              accept;
    logic              commit;
    logic [WORDS-1:0]  word_we;
    logic [ROW_W-1:0]  staging;

    assign word_bus.in_ready = (state == CAPTURE);
    assign accept            = word_bus.in_valid && word_bus.in_ready;
    // frame_start during COMMIT suppresses the bank shift entirely
    assign commit            = (state == COMMIT) && !frame_start;
    assign word_we           = accept ? (WORDS'(1) << idx) : '0;

    replace_row_reg #(.WORDS(WORDS), .DW_WORD(WORD_W)) u_staging (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_start),
        .load    (1'b0),
        .word_we (word_we),
        .d       ({WORDS{word_bus.data_in}}),
        .q       (staging)
    );

    replace_row_reg #(.WORDS(WORDS), .DW_WORD(WORD_W)) u_line3 (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_start),
        .load    (commit),
        .word_we ('0),
        .d       (staging),
        .q       (imo_replace_line3)
    );

    replace_row_reg #(.WORDS(WORDS), .DW_WORD(WORD_W)) u_line2 (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_start),
        .load    (commit),
        .word_we ('0),
        .d       (imo_replace_line3),
        .q       (imo_replace_line2)
    );

    replace_row_reg #(.WORDS(WORDS), .DW_WORD(WORD_W)) u_line1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_start),
        .load    (commit),
        .word_we ('0),
        .d       (imo_replace_line2),
        .q       (imo_replace_line1)
    );

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            state      <= IDLE;
            idx        <= 3'd0;
            row_cnt    <= '0;
            store_done <= 1'b0;
        end else begin
            store_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_start) begin
                        state <= CAPTURE;
                        idx   <= 3'd0;
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'(WORDS - 1)) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    store_done <= 1'b1;
                    if (row_cnt != {ROW_CNT_WIDTH{1'b1}}) begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_array_store.sv
// tb/tb_array_store.sv - directed self-checking bench for array_store
module tb_array_store;
    localparam int W = 40;
    localparam int R = W * 7;

    logic clk = 1'b0;
    logic rst, frame_start, store_start;
    always #5 clk = ~clk;

    array_store_if #(.WIDTH(W)) bus  ();
    array_store_if #(.WIDTH(W)) bus2 ();
    assign bus2.in_valid = bus.in_valid;
    assign bus2.data_in  = bus.data_in;

    logic [R-1:0] line1, line2, line3, l1b, l2b, l3b;
    logic [3:0]   row_cnt;
    logic [1:0]   row_cnt_b;
    logic         store_done, store_done_b;

    array_store dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .store_start(store_start),
        .word_bus(bus.slave),
        .imo_replace_line1(line1), .imo_replace_line2(line2), .imo_replace_line3(line3),
        .row_cnt(row_cnt), .store_done(store_done)
    );

    array_store #(.ROW_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .frame_start(frame_start), .store_start(store_start),
        .word_bus(bus2.slave),
        .imo_replace_line1(l1b), .imo_replace_line2(l2b), .imo_replace_line3(l3b),
        .row_cnt(row_cnt_b), .store_done(store_done_b)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [R-1:0] exp1, exp2, exp3;
    int           exp_cnt, exp_cnt_b;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [R-1:0] obs, input logic [R-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [R-1:0] row_of(input logic [W-1:0] base);
        logic [R-1:0] r;
        for (int k = 0; k < 7; k++) r[k*W +: W] = base + W'(k);
        return r;
    endfunction

    task automatic model_clear;
        exp1 = '0; exp2 = '0; exp3 = '0; exp_cnt = 0; exp_cnt_b = 0;
    endtask

    task automatic model_push(input logic [R-1:0] row);
        exp1 = exp2; exp2 = exp3; exp3 = row;
        if (exp_cnt < 15) exp_cnt++;
        if (exp_cnt_b < 3) exp_cnt_b++;
    endtask

    task automatic check_bank(input string tag);
        chk({tag, "_line1"}, line1, exp1);
        chk({tag, "_line2"}, line2, exp2);
        chk({tag, "_line3"}, line3, exp3);
        chk({tag, "_row_cnt"}, R'(row_cnt), R'(exp_cnt));
        chk({tag, "_row_cnt_sat"}, R'(row_cnt_b), R'(exp_cnt_b));
    endtask

    task automatic beat(input logic [W-1:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        while (!bus.in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("beat_ready", R'(bus.in_ready), R'(1'b1));
        tick;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
    endtask

    task automatic start_row;
        store_start = 1'b1;
        tick;
        store_start = 1'b0;
    endtask

    // called right after the edge that accepted the last beat
    task automatic finish_commit(input string tag, input logic [R-1:0] row);
        chk({tag, "_ready_drop"}, R'(bus.in_ready), R'(1'b0));
        chk({tag, "_done_early"}, R'(store_done), R'(1'b0));
        tick;
        chk({tag, "_done"}, R'(store_done), R'(1'b1));
        model_push(row);
        check_bank(tag);
        tick;
        chk({tag, "_done_pulse"}, R'(store_done), R'(1'b0));
    endtask

    task automatic send_row(input string tag, input logic [W-1:0] base, input logic [6:0] gaps);
        start_row;
        for (int k = 0; k < 7; k++) begin
            if (gaps[k]) begin
                tick;
                tick;
            end
            beat(base + W'(k));
        end
        finish_commit(tag, row_of(base));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; store_start = 1'b0;
        bus.in_valid = 1'b0; bus.data_in = '0;
        model_clear;
        tick; tick;
        rst = 1'b0;
        check_bank("reset");
        chk("reset_ready", R'(bus.in_ready), R'(1'b0));
        chk("reset_done", R'(store_done), R'(1'b0));

        send_row("one_row", 40'h001, 7'b0);

        // reset in the middle of a capture
        start_row;
        beat(40'h050); beat(40'h051); beat(40'h052);
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        model_clear;
        check_bank("mid_reset");
        chk("mid_reset_ready", R'(bus.in_ready), R'(1'b0));
        chk("mid_reset_done", R'(store_done), R'(1'b0));

        send_row("rot_a", 40'h100, 7'b0);
        send_row("rot_b", 40'h200, 7'b0);
        send_row("rot_c", 40'h300, 7'b0);
        send_row("rot_d", 40'h400, 7'b0);

        // in_valid while idle must be dropped
        bus.in_valid = 1'b1; bus.data_in = 40'hdead_beef;
        tick; tick;
        bus.in_valid = 1'b0; bus.data_in = '0;
        check_bank("idle_valid");
        chk("idle_valid_ready", R'(bus.in_ready), R'(1'b0));

        send_row("gaps", 40'h001, 7'b0101101);

        // abort a partial capture with frame_start
        start_row;
        beat(40'h070); beat(40'h071); beat(40'h072);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        model_clear;
        check_bank("abort");
        chk("abort_ready", R'(bus.in_ready), R'(1'b0));
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", R'(store_done), R'(1'b0));
            tick;
        end
        send_row("after_abort", 40'h030, 7'b0);

        // frame_start wins over a same-cycle store_start
        frame_start = 1'b1; store_start = 1'b1;
        tick;
        frame_start = 1'b0; store_start = 1'b0;
        model_clear;
        chk("fs_ss_ready", R'(bus.in_ready), R'(1'b0));
        check_bank("fs_ss");

        // frame_start landing in the COMMIT cycle
        send_row("pre_collide", 40'h060, 7'b0);
        start_row;
        for (int k = 0; k < 7; k++) beat(40'h080 + W'(k));
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        model_clear;
        chk("collide_done", R'(store_done), R'(1'b0));
        check_bank("collide");
        tick;
        chk("collide_done_late", R'(store_done), R'(1'b0));

        // store_start during capture does not restart the word index
        start_row;
        beat(40'h090); beat(40'h091); beat(40'h092);
        store_start = 1'b1;
        beat(40'h093);
        store_start = 1'b0;
        beat(40'h094); beat(40'h095); beat(40'h096);
        finish_commit("ss_in_capture", row_of(40'h090));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
